load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit that sits directly downstream of the execution unit. It consumes the effective address, the forwarded store data, the instruction ID and the valid flag carried through the EX/MEM pipeline register. It runs a request/response handshake with the data memory, aligns and sign- or zero-extends load data, and builds byte strobes for stores. While an access is outstanding it stalls the pipeline, and it reports misaligned accesses and bus time-outs to the trap logic.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ or WAIT before the access is aborted. 0 disables the watchdog.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid_in` input 1: the EX/MEM slot holds a live instruction.
- `instr_id` input 6: decoded ID, using INSTR_LB/LH/LW/LBU/LHU/SB/SH/SW from instr_defines.vh.
- `mem_addr` input 32: effective address (rs1 + imm) from the execution unit.
- `store_data` input 32: forwarded rs2 value.
- `rd_addr_in` input 5: destination register of the instruction.
- `stall_out` output 1: hold IF..EX/MEM this cycle.
- `result_valid` output 1: one-cycle pulse; a load result is ready for MEM/WB.
- `load_data` output 32: extended load value.
- `rd_addr_out` output 5: latched rd of the completed load.
- `misaligned_load`, `misaligned_store` output 1: one-cycle exception pulses.
- `bus_error` output 1: one-cycle pulse when the watchdog aborts an access.
- `fault_addr` output 32: faulting address, valid with any exception pulse.
- `dmem_req` output 1, `dmem_we` output 1, `dmem_addr` output 32 (word aligned), `dmem_wdata` output 32, `dmem_wstrb` output 4: request channel.
- `dmem_ready` input 1: request accepted this cycle.
- `dmem_rvalid` input 1, `dmem_rdata` input 32: read response.

## Operation
- A memory op is `valid_in` together with an ID in the LB..SW set. Every other instruction is ignored: no stall and no outputs.
- Misalignment rules:
  - LH/LHU/SH are misaligned when addr[0] = 1.
  - LW/SW are misaligned when addr[1:0] ≠ 0.
  - Byte accesses are never misaligned.
- When a memory op is seen in IDLE and it is misaligned:
  - `misaligned_load` or `misaligned_store` is high in the same cycle (combinational), with `fault_addr` = `mem_addr`.
  - There is no stall, no request, and the state stays IDLE.
- When a memory op is seen in IDLE and it is aligned:
  - Latch addr, op, rd, `dmem_wdata` and `dmem_wstrb`, then go to REQ.
  - `stall_out` is high in this start cycle.
- Store formatting, with off = addr[1:0]:
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << off.
  - SH: wdata = {2{data[15:0]}}, wstrb = 4'b0011 << off.
  - SW: wdata = data, wstrb = 4'b1111.
  - For loads, wstrb = 0.
- `dmem_addr` = {addr[31:2], 2'b00}.
- State machine:
  - IDLE → REQ on an aligned memory op.
  - REQ: `dmem_req` = 1, `dmem_we` = 1 for stores. On `dmem_ready`, a store goes to DONE and a load goes to WAIT.
  - WAIT: on `dmem_rvalid`, capture the extended data and go to DONE.
  - DONE: lasts one cycle, then IDLE. `valid_in`/`instr_id` are ignored in DONE, because they still show the instruction just completed.
- Load extraction:
  - LB/LBU take byte rdata[8·off+7 : 8·off].
  - LH/LHU take half rdata[16·addr[1]+15 : 16·addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through.
- Watchdog: a counter clears on entry to REQ and again on entry to WAIT. When it reaches `TIMEOUT_CYCLES`, go to DONE with the error flagged. Only `dmem_ready`/`dmem_rvalid` in the same cycle as the timeout takes priority over the timeout.
- A `dmem_rvalid` arriving outside WAIT is dropped.

## Timing
- Reset (asynchronous):
  - State goes to IDLE and the watchdog counter clears.
  - Every output goes to 0, including `dmem_req`, `load_data`, `fault_addr` and `rd_addr_out`.
  - A reset in the middle of an access drops `dmem_req` immediately. The in-flight access is abandoned and a late `rvalid` after reset is ignored.
- `stall_out` = (IDLE & aligned memory op) | REQ | WAIT. It is low in DONE, so the completed instruction advances on that edge.
- DONE cycle outputs:
  - For a load: `result_valid` = 1, with `load_data` and `rd_addr_out` registered and stable.
  - For a store: `result_valid` = 0.
  - On a watchdog abort: `bus_error` = 1, `fault_addr` = latched addr, `result_valid` = 0.
- Minimum latency (`ready` in the first REQ cycle, `rvalid` one cycle later):
  - Load: 4 cycles start→DONE, 3 stall cycles.
  - Store: 3 cycles, 2 stall cycles.
- Request channel:
  - `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are registered.
  - They are stable throughout REQ until the cycle `dmem_ready` is sampled high.
  - `dmem_req` deasserts on the next edge.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after DONE, with no bubble beyond DONE itself.

## Test plan
- LW at 0x100, ready immediately, rvalid next cycle with rdata 0xDEADBEEF → stall for 3 cycles, `result_valid` pulse with `load_data` = 0xDEADBEEF, `dmem_addr` = 0x100.
- LB at 0x203 with rdata 0x80FF_0000 → `load_data` = 0xFFFFFF80; LBU at the same address → 0x00000080. LHU at 0x202 → 0x000080FF.
- SB at 0x301 with `store_data` 0x12345678 → `dmem_wdata` 0x78787878, `wstrb` 4'b0010, `we` = 1, 2 stall cycles, no `result_valid`.
- SH at 0x401 → `misaligned_store` pulse in the same cycle, `fault_addr` 0x401, no `dmem_req`, no stall. LW at 0x402 → `misaligned_load`.
- `TIMEOUT_CYCLES` = 4 and `dmem_ready` held low → `req` held for 4 cycles, then DONE with `bus_error` = 1, `fault_addr` = addr, and `stall_out` drops.
- Assert `rst` during WAIT, then fire `rvalid` → outputs go to 0 asynchronously, `result_valid` stays 0, and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: request/response handshake with the data
// memory, load alignment and extension, store lane replication and strobes,
// misalignment detection and a watchdog that aborts stuck accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  instr_id,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr_in,
    output logic        stall_out,
    output logic        result_valid,
    output logic [31:0] load_data,
    output logic [4:0]  rd_addr_out,
    output logic        misaligned_load,
    output logic        misaligned_store,
    output logic        bus_error,
    output logic [31:0] fault_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    // Instruction IDs shared with the decoder
    localparam logic [5:0] INSTR_LB  = 6'h10;
    localparam logic [5:0] INSTR_LH  = 6'h11;
    localparam logic [5:0] INSTR_LW  = 6'h12;
    localparam logic [5:0] INSTR_LBU = 6'h13;
    localparam logic [5:0] INSTR_LHU = 6'h14;
    localparam logic [5:0] INSTR_SB  = 6'h15;
    localparam logic [5:0] INSTR_SH  = 6'h16;
    localparam logic [5:0] INSTR_SW  = 6'h17;

    // Counter only needs to reach TIMEOUT_CYCLES-1; the access aborts in that cycle
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wd_cnt_q;
    logic [31:0]   addr_q;
    logic [5:0]    op_q;
    logic [4:0]    rd_q;
    logic          dmem_req_q;
    logic          dmem_we_q;
    logic [31:0]   dmem_addr_q;
    logic [31:0]   dmem_wdata_q;
    logic [3:0]    dmem_wstrb_q;
    logic          result_valid_q;
    logic [31:0]   load_data_q;
    logic [4:0]    rd_out_q;
    logic          bus_error_q;
    logic [31:0]   fault_q;

    logic        is_mem;
    logic        is_load;
    logic        is_store;
    logic        misal;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic        mem_op_idle;
    logic        start;
    logic        timeout;
    logic [31:0] rdata_shifted;
    logic [15:0] rdata_half;
    logic [31:0] load_ext;

    // Decode the incoming instruction: class, alignment and store formatting
    always_comb begin
        is_mem   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        wdata_d  = '0;
        wstrb_d  = '0;
        case (instr_id)
            INSTR_LB, INSTR_LBU: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            INSTR_LH, INSTR_LHU: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                misal   = mem_addr[0];
            end
            INSTR_LW: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                misal   = |mem_addr[1:0];
            end
            INSTR_SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                wdata_d  = {4{store_data[7:0]}};
                wstrb_d  = 4'b0001 << mem_addr[1:0];
            end
            INSTR_SH: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                misal    = mem_addr[0];
                wdata_d  = {2{store_data[15:0]}};
                wstrb_d  = 4'b0011 << mem_addr[1:0];
            end
            INSTR_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                misal    = |mem_addr[1:0];
                wdata_d  = store_data;
                wstrb_d  = 4'b1111;
            end
            default: begin
                is_mem = 1'b0;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        rdata_shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
        rdata_half    = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            INSTR_LB:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            INSTR_LBU: load_ext = {24'h000000, rdata_shifted[7:0]};
            INSTR_LH:  load_ext = {{16{rdata_half[15]}}, rdata_half};
            INSTR_LHU: load_ext = {16'h0000, rdata_half};
            default:   load_ext = dmem_rdata;
        endcase
    end

    // Combinational handshake with the pipeline; held quiet while reset is asserted
    always_comb begin
        mem_op_idle      = !rst && valid_in && is_mem && (state_q == S_IDLE);
        start            = mem_op_idle && !misal;
        misaligned_load  = mem_op_idle && misal && is_load;
        misaligned_store = mem_op_idle && misal && is_store;
        stall_out        = start || (state_q == S_REQ) || (state_q == S_WAIT);
        fault_addr       = (misaligned_load || misaligned_store) ? mem_addr : fault_q;
        timeout          = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == CNT_LAST);
    end

    // Access sequencer with registered request channel and result/error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wd_cnt_q       <= '0;
            addr_q         <= '0;
            op_q           <= '0;
            rd_q           <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            dmem_wstrb_q   <= '0;
            result_valid_q <= 1'b0;
            load_data_q    <= '0;
            rd_out_q       <= '0;
            bus_error_q    <= 1'b0;
            fault_q        <= '0;
        end else begin
            result_valid_q <= 1'b0;
            bus_error_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q       <= mem_addr;
                        op_q         <= instr_id;
                        rd_q         <= rd_addr_in;
                        dmem_addr_q  <= {mem_addr[31:2], 2'b00};
                        dmem_wdata_q <= wdata_d;
                        dmem_wstrb_q <= wstrb_d;
                        dmem_we_q    <= is_store;
                        dmem_req_q   <= 1'b1;
                        wd_cnt_q     <= '0;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        wd_cnt_q   <= '0;
                        state_q    <= dmem_we_q ? S_DONE : S_WAIT;
                    end else if (timeout) begin
                        dmem_req_q  <= 1'b0;
                        bus_error_q <= 1'b1;
                        fault_q     <= addr_q;
                        state_q     <= S_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        load_data_q    <= load_ext;
                        rd_out_q       <= rd_q;
                        result_valid_q <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (timeout) begin
                        bus_error_q <= 1'b1;
                        fault_q     <= addr_q;
                        state_q     <= S_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result_valid = result_valid_q;
    assign load_data    = load_data_q;
    assign rd_addr_out  = rd_out_q;
    assign bus_error    = bus_error_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign dmem_wstrb   = dmem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// requests and responses, a negedge monitor pops and compares them.
module tb_load_store_unit;

    localparam int T = 4;

    localparam logic [5:0] LB  = 6'h10;
    localparam logic [5:0] LH  = 6'h11;
    localparam logic [5:0] LW  = 6'h12;
    localparam logic [5:0] LBU = 6'h13;
    localparam logic [5:0] LHU = 6'h14;
    localparam logic [5:0] SB  = 6'h15;
    localparam logic [5:0] SH  = 6'h16;
    localparam logic [5:0] SW  = 6'h17;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reqExp_t;

    // kind bits: {result_valid, misaligned_load, misaligned_store, bus_error}
    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
        logic [4:0]  rd;
    } respExp_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [5:0]  instr_id;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr_in;
    logic        stall_out;
    logic        result_valid;
    logic [31:0] load_data;
    logic [4:0]  rd_addr_out;
    logic        misaligned_load;
    logic        misaligned_store;
    logic        bus_error;
    logic [31:0] fault_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    reqExp_t  reqQ[$];
    respExp_t respQ[$];
    reqExp_t  monReq;
    respExp_t monResp;

    logic [5:0] memOps [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .instr_id         (instr_id),
        .mem_addr         (mem_addr),
        .store_data       (store_data),
        .rd_addr_in       (rd_addr_in),
        .stall_out        (stall_out),
        .result_valid     (result_valid),
        .load_data        (load_data),
        .rd_addr_out      (rd_addr_out),
        .misaligned_load  (misaligned_load),
        .misaligned_store (misaligned_store),
        .bus_error        (bus_error),
        .fault_addr       (fault_addr),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ready       (dmem_ready),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int accessSize(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit isLoadOp(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic bit isSignedOp(input logic [5:0] op);
        return (op == LB) || (op == LH);
    endfunction

    // Each byte lane carries the data byte at (lane mod access size)
    function automatic logic [31:0] storeLanes(input logic [5:0] op, input logic [31:0] data);
        int size;
        logic [31:0] r;
        size = accessSize(op);
        r = '0;
        if (size == 0 || isLoadOp(op)) return r;
        for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = data[8*(lane % size) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] strobeModel(input logic [5:0] op, input logic [31:0] addr);
        int size;
        int off;
        logic [3:0] r;
        size = accessSize(op);
        off = int'(addr[1:0]);
        r = '0;
        if (isLoadOp(op)) return r;
        for (int lane = 0; lane < 4; lane++) if (lane >= off && lane < off + size) r[lane] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] loadModel(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int size;
        int off;
        logic [31:0] v;
        logic [31:0] mask;
        size = accessSize(op);
        off = int'(addr[1:0]);
        v = rdata >> (8 * off);
        if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v = v & mask;
            if (isSignedOp(op) && v[8*size-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input bit vld, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int rdyDly, input int rvDly);
        int size;
        bit memOp;
        bit load;
        bit mis;
        bit accepted;
        int reqCycles;
        int waitCycles;
        int expStall;
        int stallCnt;
        reqExp_t re;
        respExp_t rs;
        size = accessSize(op);
        memOp = vld && (size != 0);
        load = isLoadOp(op);
        mis = memOp ? ((int'(addr[1:0]) % size) != 0) : 1'b0;
        valid_in = vld;
        instr_id = op;
        mem_addr = addr;
        store_data = sdata;
        rd_addr_in = rd;
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        if (!memOp || mis) begin
            if (mis) begin
                rs.kind = load ? 4'b0100 : 4'b0010;
                rs.data = addr;
                rs.rd = '0;
                respQ.push_back(rs);
            end
            @(negedge clk);
            checkOutput("idle_stall", stall_out, 0);
            checkOutput("idle_req", dmem_req, 0);
            step();
            valid_in = 1'b0;
            return;
        end
        accepted = rdyDly < T;
        reqCycles = accepted ? rdyDly + 1 : T;
        waitCycles = (accepted && load) ? ((rvDly < T) ? rvDly + 1 : T) : 0;
        expStall = 1 + reqCycles + waitCycles;
        if (accepted) begin
            re.addr = {addr[31:2], 2'b00};
            re.we = !load;
            re.wdata = storeLanes(op, sdata);
            re.wstrb = strobeModel(op, addr);
            reqQ.push_back(re);
        end
        if (!accepted || (load && rvDly >= T)) begin
            rs.kind = 4'b0001;
            rs.data = addr;
            rs.rd = '0;
            respQ.push_back(rs);
        end else if (load) begin
            rs.kind = 4'b1000;
            rs.data = loadModel(op, addr, rdata);
            rs.rd = rd;
            respQ.push_back(rs);
        end
        @(negedge clk);
        stallCnt = stall_out ? 1 : 0;
        step();
        for (int c = 0; c < reqCycles; c++) begin
            dmem_ready = (c == rdyDly);
            dmem_rvalid = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            @(negedge clk);
            if (stall_out) stallCnt++;
            checkOutput("req_held", dmem_req, 1);
            step();
        end
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        for (int c = 0; c < waitCycles; c++) begin
            dmem_rvalid = (c == rvDly);
            dmem_rdata = (c == rvDly) ? rdata : $urandom;
            @(negedge clk);
            if (stall_out) stallCnt++;
            checkOutput("req_dropped", dmem_req, 0);
            step();
        end
        dmem_rvalid = ($urandom_range(0, 1) == 1);
        dmem_rdata = $urandom;
        @(negedge clk);
        checkOutput("done_stall", stall_out, 0);
        checkOutput("done_req", dmem_req, 0);
        checkOutput("stall_cycles", stallCnt, expStall);
        step();
        valid_in = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #3 rst = 1'b0;
        step();
    endtask

    task automatic resetDuringReq(input logic [31:0] addr);
        reqExp_t dummy;
        valid_in = 1'b1;
        instr_id = SW;
        mem_addr = addr;
        store_data = $urandom;
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        checkOutput("req_before_rst", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_req_drop", dmem_req, 0);
        checkOutput("rst_req_stall", stall_out, 0);
        valid_in = 1'b0;
        dummy.addr = '0;
        releaseReset();
    endtask

    task automatic resetDuringWait(input logic [31:0] addr);
        reqExp_t re;
        valid_in = 1'b1;
        instr_id = LW;
        mem_addr = addr;
        rd_addr_in = 5'd9;
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        re.addr = addr;
        re.we = 1'b0;
        re.wdata = '0;
        re.wstrb = 4'b0000;
        reqQ.push_back(re);
        @(negedge clk);
        step();
        dmem_ready = 1'b1;
        @(negedge clk);
        step();
        dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("wait_stall", stall_out, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_stall", stall_out, 0);
        checkOutput("rst_req", dmem_req, 0);
        checkOutput("rst_result_valid", result_valid, 0);
        checkOutput("rst_load_data", load_data, 0);
        checkOutput("rst_rd_out", rd_addr_out, 0);
        checkOutput("rst_fault_addr", fault_addr, 0);
        checkOutput("rst_bus_error", bus_error, 0);
        valid_in = 1'b0;
        releaseReset();
        dmem_rvalid = 1'b1;
        dmem_rdata = $urandom;
        @(negedge clk);
        checkOutput("late_rvalid", result_valid, 0);
        checkOutput("late_rvalid_stall", stall_out, 0);
        step();
        dmem_rvalid = 1'b0;
    endtask

    // Monitor: pop the expected request/response whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req && dmem_ready) begin
                if (reqQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got handshake at 0x%08h, expected none", dmem_addr);
                end else begin
                    monReq = reqQ.pop_front();
                    checkOutput("dmem_addr", dmem_addr, monReq.addr);
                    checkOutput("dmem_we", dmem_we, monReq.we);
                    checkOutput("dmem_wstrb", dmem_wstrb, monReq.wstrb);
                    if (monReq.we) checkOutput("dmem_wdata", dmem_wdata, monReq.wdata);
                end
            end
            if (result_valid || misaligned_load || misaligned_store || bus_error) begin
                if (respQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got flags %b, expected none",
                             {result_valid, misaligned_load, misaligned_store, bus_error});
                end else begin
                    monResp = respQ.pop_front();
                    checkOutput("resp_kind",
                                {result_valid, misaligned_load, misaligned_store, bus_error},
                                monResp.kind);
                    if (monResp.kind == 4'b1000) begin
                        checkOutput("load_data", load_data, monResp.data);
                        checkOutput("rd_addr_out", rd_addr_out, monResp.rd);
                    end else begin
                        checkOutput("fault_addr", fault_addr, monResp.data);
                    end
                end
            end
        end
    end

    // Directed cases, randomized traffic, then reset-in-flight scenarios
    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        bit          vld;
        int          pick;
        int          rdy;
        int          rv;
        rst = 1'b1;
        valid_in = 1'b0;
        instr_id = '0;
        mem_addr = '0;
        store_data = '0;
        rd_addr_in = '0;
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        #7;
        checkOutput("reset_stall", stall_out, 0);
        checkOutput("reset_result_valid", result_valid, 0);
        checkOutput("reset_load_data", load_data, 0);
        checkOutput("reset_rd_out", rd_addr_out, 0);
        checkOutput("reset_mis_load", misaligned_load, 0);
        checkOutput("reset_mis_store", misaligned_store, 0);
        checkOutput("reset_bus_error", bus_error, 0);
        checkOutput("reset_fault_addr", fault_addr, 0);
        checkOutput("reset_req", dmem_req, 0);
        checkOutput("reset_we", dmem_we, 0);
        checkOutput("reset_addr", dmem_addr, 0);
        checkOutput("reset_wdata", dmem_wdata, 0);
        checkOutput("reset_wstrb", dmem_wstrb, 0);
        releaseReset();

        applyStimulus(LW,  1, 32'h0000_0100, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(LB,  1, 32'h0000_0203, 32'h0, 5'd4, 32'h80FF_0000, 0, 0);
        applyStimulus(LBU, 1, 32'h0000_0203, 32'h0, 5'd5, 32'h80FF_0000, 0, 0);
        applyStimulus(LHU, 1, 32'h0000_0202, 32'h0, 5'd6, 32'h80FF_0000, 0, 0);
        applyStimulus(LH,  1, 32'h0000_0202, 32'h0, 5'd7, 32'h80FF_0000, 1, 2);
        applyStimulus(SB,  1, 32'h0000_0301, 32'h1234_5678, 5'd0, 32'h0, 0, 0);
        applyStimulus(SH,  1, 32'h0000_0401, 32'h1234_5678, 5'd0, 32'h0, 0, 0);
        applyStimulus(LW,  1, 32'h0000_0402, 32'h0, 5'd8, 32'h0, 0, 0);
        applyStimulus(LW,  1, 32'h0000_0500, 32'h0, 5'd1, 32'h0, T, 0);
        applyStimulus(SW,  1, 32'h0000_0504, 32'hCAFE_F00D, 5'd0, 32'h0, T, 0);
        applyStimulus(LH,  1, 32'h0000_0602, 32'h0, 5'd2, 32'h1234_5678, 0, T);
        applyStimulus(LW,  1, 32'h0000_0700, 32'h0, 5'd11, 32'h0BAD_CAFE, T - 1, T - 1);
        applyStimulus(SH,  1, 32'h0000_0802, 32'hAAAA_5555, 5'd0, 32'h0, T - 1, 0);
        applyStimulus(6'h00, 1, 32'h0000_0900, 32'h0, 5'd1, 32'h0, 0, 0);
        applyStimulus(LW,  0, 32'h0000_0900, 32'h0, 5'd1, 32'h0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            vld = 1'b1;
            if (pick < 8) begin
                op = memOps[$urandom_range(0, 7)];
            end else if (pick == 8) begin
                op = 6'($urandom_range(0, 63));
            end else begin
                op = memOps[$urandom_range(0, 7)];
                vld = 1'b0;
            end
            addr = $urandom;
            case ($urandom_range(0, 2))
                0: addr[1:0] = 2'b00;
                1: addr[0] = 1'b0;
                default: addr[0] = addr[0];
            endcase
            rdy = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1);
            rv  = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1);
            applyStimulus(op, vld, addr, $urandom, 5'($urandom_range(0, 31)), $urandom, rdy, rv);
            if ($urandom_range(0, 3) == 0) step();
        end

        resetDuringReq(32'h0000_1000);
        applyStimulus(LW, 1, 32'h0000_1100, 32'h0, 5'd12, 32'h1357_9BDF, 0, 0);
        resetDuringWait(32'h0000_1200);
        applyStimulus(LW, 1, 32'h0000_1300, 32'h0, 5'd13, 32'h2468_ACE0, 0, 0);

        repeat (3) step();
        checkOutput("req_queue_empty", reqQ.size(), 0);
        checkOutput("resp_queue_empty", respQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
